// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the even-parity bit after data bit 7.
module uart_tx_module #(
  parameter int CLK_DIV = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Pin_Out,
  output logic       TX_Busy,
  output logic       TX_Done_Sig
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            pin_q, pin_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            baud_end_s;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    pin_d      = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    baud_end_s = (baud_cnt_q == BAUD_LAST);

    if (state_q == S_IDLE) begin
      baud_cnt_d = '0;
    end else if (baud_end_s) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + BAUD_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (TX_En_Sig) begin
          state_d   = S_START;
          shreg_d   = TX_Data;
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^TX_Data;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end_s) begin
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (baud_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_IDLE:   pin_d = 1'b1;
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: pin_d = parity_d;
`endif
      S_STOP:   pin_d = 1'b1;
      default:  pin_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    // Done must be visible during the final stop cycle itself, hence the look-ahead.
    done_d = (state_d == S_STOP) && (baud_cnt_d == BAUD_LAST);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      pin_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      pin_q      <= pin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign TX_Pin_Out  = pin_q;
  assign TX_Busy     = busy_q;
  assign TX_Done_Sig = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed self-checking bench for uart_tx_module (CLK_DIV=4 and CLK_DIV=434 instances).
// Honours UART_TX_PARITY_EN for the expected frame length and parity bit.
module tb_uart_tx_module;

  localparam int D  = 4;
  localparam int DL = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * D;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, en_l;
  logic [7:0] data;
  logic       pin, busy, done;
  logic       pin_l, busy_l, done_l;

  int checks   = 0;
  int failures = 0;

  logic cap_pin  [1:FL+1];
  logic cap_busy [1:FL+1];
  logic cap_done [1:FL+1];

  always #5 clk = ~clk;

  uart_tx_module #(.CLK_DIV(D)) dut (
    .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data),
    .TX_Pin_Out(pin), .TX_Busy(busy), .TX_Done_Sig(done)
  );

  uart_tx_module #(.CLK_DIV(DL)) dut_l (
    .CLK(clk), .RST(rst), .TX_En_Sig(en_l), .TX_Data(data),
    .TX_Pin_Out(pin_l), .TX_Busy(busy_l), .TX_Done_Sig(done_l)
  );

  // Expected line level in cycle t+k of a frame carrying d (k=0 is the accept cycle).
  function automatic logic exp_pin(input logic [7:0] d, input int k, input int div);
    int b;
    logic [7:0] v;
    v = d;
    if (k < 1) return 1'b1;
    b = (k - 1) / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return v[3'(b - 1)];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    en   = 1'b1;
    data = d;
    @(posedge clk);
  endtask

  // Records outputs for cycles t+1..t+FL+1; optionally changes data / pulses en mid-frame.
  task automatic capture(input int chg_k, input logic [7:0] chg_v,
                         input int inj_k, input logic [7:0] inj_v);
    for (int k = 1; k <= FL + 1; k++) begin
      @(negedge clk);
      cap_pin[k]  = pin;
      cap_busy[k] = busy;
      cap_done[k] = done;
      if (k == chg_k) data = chg_v;
      if (k == inj_k) begin
        en   = 1'b1;
        data = inj_v;
      end else begin
        en = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; en_l = 1'b0; data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (pin !== 1'b1)    begin failures++; $display("FAIL reset_pin got=%b exp=1", pin); end
    if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (pin_l !== 1'b1)  begin failures++; $display("FAIL reset_pin_l got=%b exp=1", pin_l); end
    if (busy_l !== 1'b0) begin failures++; $display("FAIL reset_busy_l got=%b exp=0", busy_l); end
    if (done_l !== 1'b0) begin failures++; $display("FAIL reset_done_l got=%b exp=0", done_l); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_patterns;
    logic [7:0] pats [5];
    pats = '{8'h55, 8'h07, 8'h03, 8'h00, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      start_frame(pats[i]);
      capture(0, 8'h00, 0, 8'h00);
      for (int k = 1; k <= FL + 1; k++) begin
        checks += 3;
        if (cap_pin[k] !== exp_pin(pats[i], k, D)) begin
          failures++; $display("FAIL pat_pin d=%02h k=%0d got=%b exp=%b", pats[i], k, cap_pin[k], exp_pin(pats[i], k, D));
        end
        if (cap_busy[k] !== (k <= FL)) begin
          failures++; $display("FAIL pat_busy d=%02h k=%0d got=%b exp=%b", pats[i], k, cap_busy[k], (k <= FL));
        end
        if (cap_done[k] !== (k == FL)) begin
          failures++; $display("FAIL pat_done d=%02h k=%0d got=%b exp=%b", pats[i], k, cap_done[k], (k == FL));
        end
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_ignore;
    int npulse;
    npulse = 0;
    start_frame(8'hA3);
    capture(5, 8'h3C, 10, 8'hFF);
    for (int k = 1; k <= FL + 1; k++) begin
      checks += 2;
      if (cap_pin[k] !== exp_pin(8'hA3, k, D)) begin
        failures++; $display("FAIL ign_pin k=%0d got=%b exp=%b", k, cap_pin[k], exp_pin(8'hA3, k, D));
      end
      if (cap_done[k] !== (k == FL)) begin
        failures++; $display("FAIL ign_done k=%0d got=%b exp=%b", k, cap_done[k], (k == FL));
      end
      if (cap_done[k] === 1'b1) npulse++;
    end
    for (int k = 0; k < 2 * FL; k++) begin
      @(negedge clk);
      if (done === 1'b1) npulse++;
      checks++;
      if (busy !== 1'b0 || pin !== 1'b1) begin
        failures++; $display("FAIL ign_idle k=%0d busy=%b pin=%b exp busy=0 pin=1", k, busy, pin);
      end
    end
    checks++;
    if (npulse !== 1) begin failures++; $display("FAIL ign_pulses got=%0d exp=1", npulse); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] ds [2];
    ds = '{8'h5A, 8'h81};
    start_frame(ds[0]);
    for (int f = 0; f < 2; f++) begin
      capture(0, 8'h00, 0, 8'h00);
      if (f == 0) begin
        en   = 1'b1;
        data = ds[1];
        @(posedge clk);
      end
      for (int k = 1; k <= FL + 1; k++) begin
        checks += 2;
        if (cap_pin[k] !== exp_pin(ds[f], k, D)) begin
          failures++; $display("FAIL b2b_pin f=%0d k=%0d got=%b exp=%b", f, k, cap_pin[k], exp_pin(ds[f], k, D));
        end
        if (cap_busy[k] !== (k <= FL)) begin
          failures++; $display("FAIL b2b_busy f=%0d k=%0d got=%b exp=%b", f, k, cap_busy[k], (k <= FL));
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    start_frame(8'h0F);
    for (int k = 1; k <= 4 * D + 2; k++) begin
      @(negedge clk);
      en = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (pin !== 1'b1)  begin failures++; $display("FAIL mid_rst_pin got=%b exp=1", pin); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL mid_rst_done got=%b exp=0", done); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * FL; k++) begin
      @(negedge clk);
      checks++;
      if (pin !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL mid_after k=%0d pin=%b busy=%b done=%b exp 1/0/0", k, pin, busy, done);
      end
    end
  endtask

  task automatic test_baud434;
    int   got_q [$];
    int   exp_q [$];
    logic prev_g, prev_e, e;
    int   done_k, ndone;
    prev_g = 1'b1; prev_e = 1'b1; done_k = -1; ndone = 0;
    @(negedge clk);
    en_l = 1'b1;
    data = 8'h4B;
    @(posedge clk);
    for (int k = 1; k <= NB * DL + 2; k++) begin
      @(negedge clk);
      en_l = 1'b0;
      if (pin_l !== prev_g) got_q.push_back(k);
      prev_g = pin_l;
      e = exp_pin(8'h4B, k, DL);
      if (e !== prev_e) exp_q.push_back(k);
      prev_e = e;
      if (done_l === 1'b1) begin done_k = k; ndone++; end
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL l_ntrans got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++; $display("FAIL l_trans i=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks += 2;
    if (ndone !== 1)       begin failures++; $display("FAIL l_ndone got=%0d exp=1", ndone); end
    if (done_k !== NB * DL) begin failures++; $display("FAIL l_done_k got=%0d exp=%0d", done_k, NB * DL); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_l = 1'b0; data = 8'h00;
    test_reset;
    test_patterns;
    test_ignore;
    test_back_to_back;
    test_reset_midframe;
    test_baud434;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
